sram_wb_arbiter: RTL and testbench
==================================

// Module: sram_wb_arbiter
// PURPOSE
//  Write-back arbiter directly upstream of the multi-port sram.
//  Collects write requests from NUM_SRC producers (execution lanes, load unit) over valid/ready.
//  Buffers one request per producer, grants one per cycle round-robin and drives the sram write port
//  (wr_en/write_address/new_data) from registers.
//  Exposes a pending-write lookup so readers can stall on in-flight writes.
// PARAMETERS
//  NUM_SRC     4    number of producer ports (>=2)
//  SIZE        256  sram entries; ADDR_W = $clog2(SIZE) (localparam)
//  DATA_WIDTH  64   data width, matches sram
//  RD_PORTS    3    number of pending-lookup ports, matches sram read ports
// PORTS
//  clk            in   1                     clock
//  rst_n          in   1                     async active-low reset
//  src_valid      in   [NUM_SRC]             producer request valid
//  src_ready      out  [NUM_SRC]             arbiter can accept from producer
//  src_addr       in   [NUM_SRC][ADDR_W]     target entry
//  src_data       in   [NUM_SRC][DATA_WIDTH] write data
//  wr_en          out  1                     to sram wr_en[0]
//  write_address  out  ADDR_W                to sram write_address[0]
//  new_data       out  DATA_WIDTH            to sram new_data[0]
//  rd_addr        in   [RD_PORTS][ADDR_W]    lookup addresses (same as sram read_address)
//  rd_pending     out  [RD_PORTS]            write to rd_addr[i] not yet in sram
//  busy           out  1                     any holding reg or output reg valid
// BEHAVIOUR
//  Clock/reset: one clock clk; reset rst_n asynchronous, active-low.
//  Reset (async, any time, incl. mid-operation):
//   - clears pend_valid[*], wr_en=0 and rr_ptr=0.
//   - write_address/new_data are don't-care, forced 0.
//   - Queued writes are dropped.
//   - While rst_n=0: src_ready=0, rd_pending=0, busy=0.
//  Holding regs: per source one entry {pend_valid, addr, data}.
//   - src_ready[i] = rst_n & (~pend_valid[i] | grant[i]), so a full entry being granted accepts back-to-back.
//   - Accept = src_valid & src_ready at posedge -> entry loaded.
//   - src_addr/src_data are ignored when there is no accept.
//  Arbiter (comb): grant one-hot over pend_valid, search starts at rr_ptr, wraps NUM_SRC-1 -> 0.
//  At posedge with any grant:
//   - wr_en<=1; write_address/new_data <= granted entry.
//   - The granted pend_valid clears unless reloaded the same edge.
//   - rr_ptr <= (granted idx + 1) mod NUM_SRC.
//  No grant: wr_en<=0 and rr_ptr holds.
//  Latency: accept at edge E0 -> wr_en high after E1 -> sram written at E2. Min 2 cycles, no bubbles.
//  Throughput: 1 write/cycle total. Each source sustains 1/NUM_SRC under full contention and 1/cycle when alone.
//  Fairness: a pending entry is granted within NUM_SRC cycles.
//  Ordering:
//   - Same source: strictly in order.
//   - Cross-source writes to the same addr: in grant order, not arrival order. Producers must not rely on it.
//  rd_pending[i] (comb) = OR over (pend_valid[j] & addr[j]==rd_addr[i]) | (wr_en & write_address==rd_addr[i]).
//   - Drops the cycle after the sram write edge.
//  busy = |pend_valid | wr_en.
//  No data transformation; widths pass through unchanged.
// STRUCTURE
//  Package sram_wb_pkg:
//   - default param constants;
//   - typedef wb_req_t {addr, data} parameterised via package localparams;
//   - function onehot2idx.
//  Sub-module rr_arbiter #(N): inputs req[N], ptr; output grant one-hot. Purely combinational.
//  Top holds the holding regs, rr_ptr, output regs and the lookup comparators.
// TESTING
//  - Reset then single src0 req addr=5 data=0xA5: wr_en high exactly 2nd cycle after accept with addr 5/0xA5; busy low after.
//  - All 4 sources valid every cycle with rr_ptr=0: grant order 0,1,2,3,0..., wr_en continuous, each src_ready duty 1/4.
//  - Src2 alone streams 8 reqs back-to-back: src_ready stays 1; 8 consecutive wr_en cycles in order.
//  - Src1 writes addr 9: rd_addr[0]=9 gives rd_pending=1 from accept+1 until the sram write edge, then 0; rd_addr=10 stays 0.
//  - Src0 and src3 both write addr 7 same cycle with rr_ptr=3: src3 written first, src0 last; final sram[7] = src0 data.
//  - Assert rst_n low with 3 entries pending and wr_en=1: outputs clear asynchronously; no sram write after release; rr_ptr=0.

Source files
------------

// File: rtl/sram_wb_pkg.sv
// sram_wb_pkg: shared defaults, request type and helpers for the sram write-back arbiter.
package sram_wb_pkg;
  localparam int NUM_SRC_DEF    = 4;
  localparam int SIZE_DEF       = 256;
  localparam int ADDR_W_DEF     = $clog2(SIZE_DEF);
  localparam int DATA_WIDTH_DEF = 64;
  localparam int RD_PORTS_DEF   = 3;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]     addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } wb_req_t;

  function automatic int onehot2idx(input logic [31:0] oh);
    int idx = 0;
    for (int k = 0; k < 32; k++) if (oh[k]) idx = k;
    return idx;
  endfunction
endpackage

// File: rtl/sram_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant, search starts at ptr and wraps.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);
  logic found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_wb_arbiter.sv
// sram_wb_arbiter: per-producer holding regs, round-robin grant onto the registered sram write port,
// plus pending-write lookup so readers can stall on writes not yet in the sram.
module sram_wb_arbiter
  import sram_wb_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int SIZE       = SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RD_PORTS   = RD_PORTS_DEF,
  localparam int ADDR_W    = $clog2(SIZE),
  localparam int PTR_W     = $clog2(NUM_SRC)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SRC-1:0]                   src_valid,
  output logic [NUM_SRC-1:0]                   src_ready,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]       src_addr,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   src_data,
  output logic                                 wr_en,
  output logic [ADDR_W-1:0]                    write_address,
  output logic [DATA_WIDTH-1:0]                new_data,
  input  logic [RD_PORTS-1:0][ADDR_W-1:0]      rd_addr,
  output logic [RD_PORTS-1:0]                  rd_pending,
  output logic                                 busy
);
  logic [NUM_SRC-1:0]    pend_q, pend_d, grant, accept;
  logic [ADDR_W-1:0]     addr_q [NUM_SRC];
  logic [DATA_WIDTH-1:0] data_q [NUM_SRC];
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d, gidx;
  logic                  wr_en_q;
  logic [ADDR_W-1:0]     wa_q;
  logic [DATA_WIDTH-1:0] nd_q;

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .req  (pend_q),
    .ptr  (rr_ptr_q),
    .grant(grant)
  );

  // A granted entry frees its slot this cycle, so the producer can refill it back-to-back.
  assign src_ready = {NUM_SRC{rst_n}} & (~pend_q | grant);
  assign accept    = src_valid & src_ready;
  assign pend_d    = accept | (pend_q & ~grant);
  assign gidx      = PTR_W'(onehot2idx(32'(grant)));

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant) rr_ptr_d = (gidx == PTR_W'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      wr_en_q  <= 1'b0;
      wa_q     <= '0;
      nd_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      pend_q   <= pend_d;
      wr_en_q  <= |grant;
      rr_ptr_q <= rr_ptr_d;
      if (|grant) begin
        wa_q <= addr_q[gidx];
        nd_q <= data_q[gidx];
      end
    end
  end

  // Payload is only meaningful under pend_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (accept[i]) begin
        addr_q[i] <= src_addr[i];
        data_q[i] <= src_data[i];
      end
    end
  end

  always_comb begin
    rd_pending = '0;
    for (int r = 0; r < RD_PORTS; r++) begin
      rd_pending[r] = wr_en_q && (wa_q == rd_addr[r]);
      for (int j = 0; j < NUM_SRC; j++) rd_pending[r] = rd_pending[r] | (pend_q[j] && (addr_q[j] == rd_addr[r]));
    end
  end

  assign wr_en         = wr_en_q;
  assign write_address = wa_q;
  assign new_data      = nd_q;
  assign busy          = |pend_q | wr_en_q;
endmodule

// File: tb/tb_sram_wb_arbiter.sv
// tb_sram_wb_arbiter: scenario tasks plus randomized traffic checked against a queue-level reference model.
module tb_sram_wb_arbiter;
  localparam int NS = 4, AW = 8, DW = 64, RP = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NS-1:0] src_valid = '0, src_ready;
  logic [NS-1:0][AW-1:0] src_addr = '0;
  logic [NS-1:0][DW-1:0] src_data = '0;
  logic wr_en, busy;
  logic [AW-1:0] write_address;
  logic [DW-1:0] new_data;
  logic [RP-1:0][AW-1:0] rd_addr = '0;
  logic [RP-1:0] rd_pending;

  int checks = 0, failures = 0, wr_count = 0;
  logic [DW-1:0] sram [256];

  bit mp [NS];
  logic [AW-1:0] ma [NS];
  logic [DW-1:0] md [NS];
  int mptr;
  bit mwr;
  logic [AW-1:0] mwa;
  logic [DW-1:0] mnd;

  sram_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data), .wr_en(wr_en),
    .write_address(write_address), .new_data(new_data),
    .rd_addr(rd_addr), .rd_pending(rd_pending), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) begin
    sram[write_address] <= new_data;
    wr_count <= wr_count + 1;
  end

  task automatic mreset();
    for (int i = 0; i < NS; i++) mp[i] = 0;
    mptr = 0;
    mwr = 0;
  endtask

  function automatic int mgrant();
    for (int k = 0; k < NS; k++) if (mp[(mptr + k) % NS]) return (mptr + k) % NS;
    return -1;
  endfunction

  function automatic bit mpend(input logic [AW-1:0] a);
    bit p = mwr && (mwa == a);
    for (int j = 0; j < NS; j++) if (mp[j] && ma[j] == a) p = 1;
    return p;
  endfunction

  function automatic bit mbusy();
    bit b = mwr;
    for (int j = 0; j < NS; j++) if (mp[j]) b = 1;
    return b;
  endfunction

  // Applies one cycle of producer inputs at a negedge, checks the model before and after the edge.
  task automatic cycle(input logic [NS-1:0] v, input logic [NS-1:0][AW-1:0] a, input logic [NS-1:0][DW-1:0] d);
    int g;
    logic [NS-1:0] rdy;
    src_valid = v;
    src_addr = a;
    src_data = d;
    #1;
    g = mgrant();
    for (int i = 0; i < NS; i++) begin
      rdy[i] = !mp[i] || (g == i);
      checks++;
      if (src_ready[i] !== rdy[i]) begin
        failures++;
        $display("FAIL src_ready[%0d] got=%b exp=%b t=%0t", i, src_ready[i], rdy[i], $time);
      end
    end
    for (int r = 0; r < RP; r++) begin
      checks++;
      if (rd_pending[r] !== mpend(rd_addr[r])) begin
        failures++;
        $display("FAIL rd_pending[%0d] got=%b exp=%b t=%0t", r, rd_pending[r], mpend(rd_addr[r]), $time);
      end
    end
    mwr = (g >= 0);
    if (g >= 0) begin
      mwa = ma[g];
      mnd = md[g];
      mp[g] = 0;
      mptr = (g + 1) % NS;
    end
    for (int i = 0; i < NS; i++) if (v[i] && rdy[i]) begin
      mp[i] = 1;
      ma[i] = a[i];
      md[i] = d[i];
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_en !== mwr) begin
      failures++;
      $display("FAIL wr_en got=%b exp=%b t=%0t", wr_en, mwr, $time);
    end
    checks++;
    if (busy !== mbusy()) begin
      failures++;
      $display("FAIL busy got=%b exp=%b t=%0t", busy, mbusy(), $time);
    end
    if (mwr) begin
      checks++;
      if (write_address !== mwa || new_data !== mnd) begin
        failures++;
        $display("FAIL wr_port got=%0d/%h exp=%0d/%h t=%0t", write_address, new_data, mwa, mnd, $time);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mreset();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (src_ready !== '0 || wr_en !== 1'b0 || busy !== 1'b0 || rd_pending !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%b/%b/%b exp=0", src_ready, wr_en, busy, rd_pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mreset();
  endtask

  task automatic test_single();
    logic [NS-1:0][AW-1:0] a = '0;
    logic [NS-1:0][DW-1:0] d = '0;
    a[0] = 8'd5;
    d[0] = 64'hA5;
    cycle(4'b0001, a, d);
    checks++;
    if (wr_en !== 1'b0) begin
      failures++;
      $display("FAIL single_early got=%b exp=0", wr_en);
    end
    idle(1);
    checks++;
    if (wr_en !== 1'b1 || write_address !== 8'd5 || new_data !== 64'hA5) begin
      failures++;
      $display("FAIL single_write got=%b/%0d/%h exp=1/5/a5", wr_en, write_address, new_data);
    end
    idle(1);
    checks++;
    if (busy !== 1'b0 || sram[5] !== 64'hA5) begin
      failures++;
      $display("FAIL single_done got=%b/%h exp=0/a5", busy, sram[5]);
    end
  endtask

  task automatic test_contention();
    logic [NS-1:0][AW-1:0] a;
    logic [NS-1:0][DW-1:0] d;
    int rdy_cnt [NS];
    do_reset();
    for (int i = 0; i < NS; i++) begin
      a[i] = AW'(i);
      rdy_cnt[i] = 0;
    end
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < NS; i++) d[i] = {$urandom, $urandom};
      if (k >= 1) begin
        #1;
        for (int i = 0; i < NS; i++) if (src_ready[i]) rdy_cnt[i]++;
      end
      cycle(4'hF, a, d);
      if (k >= 1) begin
        checks++;
        if (wr_en !== 1'b1 || write_address !== AW'((k - 1) % NS)) begin
          failures++;
          $display("FAIL rr_order k=%0d got=%b/%0d exp=1/%0d", k, wr_en, write_address, (k - 1) % NS);
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      checks++;
      if (rdy_cnt[i] != 4 && rdy_cnt[i] != 3) begin
        failures++;
        $display("FAIL ready_duty[%0d] got=%0d exp=3..4 of 15", i, rdy_cnt[i]);
      end
    end
    idle(5);
  endtask

  task automatic test_stream();
    logic [NS-1:0][AW-1:0] a = '0;
    logic [NS-1:0][DW-1:0] d = '0;
    int c0;
    do_reset();
    c0 = wr_count;
    for (int k = 0; k < 8; k++) begin
      a[2] = AW'(100 + k);
      d[2] = {$urandom, $urandom};
      cycle(4'b0100, a, d);
    end
    idle(2);
    checks++;
    if (wr_count - c0 != 8) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=8", wr_count - c0);
    end
  endtask

  task automatic test_same_addr();
    logic [NS-1:0][AW-1:0] a = '0;
    logic [NS-1:0][DW-1:0] d = '0;
    a[0] = 8'd7;
    a[3] = 8'd7;
    d[0] = 64'h1111;
    d[3] = 64'h3333;
    cycle(4'b1001, a, d);
    idle(1);
    checks++;
    if (write_address !== 8'd7 || new_data !== 64'h3333) begin
      failures++;
      $display("FAIL same_first got=%0d/%h exp=7/3333", write_address, new_data);
    end
    idle(1);
    checks++;
    if (new_data !== 64'h1111) begin
      failures++;
      $display("FAIL same_second got=%h exp=1111", new_data);
    end
    idle(1);
    checks++;
    if (sram[7] !== 64'h1111) begin
      failures++;
      $display("FAIL same_final got=%h exp=1111", sram[7]);
    end
  endtask

  task automatic test_pending();
    logic [NS-1:0][AW-1:0] a = '0;
    logic [NS-1:0][DW-1:0] d = '0;
    do_reset();
    rd_addr[0] = 8'd9;
    rd_addr[1] = 8'd10;
    rd_addr[2] = 8'd0;
    a[1] = 8'd9;
    d[1] = 64'h99;
    cycle(4'b0010, a, d);
    checks++;
    if (rd_pending[0] !== 1'b1 || rd_pending[1] !== 1'b0) begin
      failures++;
      $display("FAIL pend_held got=%b exp=01", rd_pending[1:0]);
    end
    idle(1);
    checks++;
    if (rd_pending[0] !== 1'b1 || wr_en !== 1'b1) begin
      failures++;
      $display("FAIL pend_wr got=%b/%b exp=1/1", rd_pending[0], wr_en);
    end
    idle(1);
    checks++;
    if (rd_pending !== '0) begin
      failures++;
      $display("FAIL pend_drop got=%b exp=0", rd_pending);
    end
  endtask

  task automatic test_async_reset();
    logic [NS-1:0][AW-1:0] a;
    logic [NS-1:0][DW-1:0] d;
    int c0;
    do_reset();
    for (int i = 0; i < NS; i++) begin
      a[i] = AW'(40 + i);
      d[i] = {$urandom, $urandom};
    end
    rd_addr[0] = 8'd41;
    rd_addr[1] = 8'd40;
    cycle(4'hF, a, d);
    idle(1);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || src_ready !== '0 || rd_pending !== '0) begin
      failures++;
      $display("FAIL async_clear got=%b/%b/%b/%b exp=0", wr_en, busy, src_ready, rd_pending);
    end
    c0 = wr_count;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mreset();
    idle(3);
    checks++;
    if (wr_count != c0) begin
      failures++;
      $display("FAIL async_nowrite got=%0d exp=%0d", wr_count - c0, 0);
    end
    for (int i = 0; i < NS; i++) a[i] = AW'(i);
    cycle(4'hF, a, d);
    cycle('0, '0, '0);
    checks++;
    if (write_address !== 8'd0) begin
      failures++;
      $display("FAIL async_ptr got=%0d exp=0", write_address);
    end
    idle(4);
  endtask

  task automatic test_random();
    logic [NS-1:0][AW-1:0] a;
    logic [NS-1:0][DW-1:0] d;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NS; i++) begin
        a[i] = AW'($urandom_range(0, 15));
        d[i] = {$urandom, $urandom};
      end
      for (int r = 0; r < RP; r++) rd_addr[r] = AW'($urandom_range(0, 15));
      cycle(NS'($urandom), a, d);
    end
    idle(5);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stream();
    test_same_addr();
    test_pending();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
